// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the five-stage MIPS core: ALU control decode,
// EX/MEM and MEM/WB operand forwarding, and load-use stall/bubble insertion.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic [31:0] id_rdata1,
  input  logic [31:0] id_rdata2,
  input  logic [31:0] id_imm,
  input  logic [5:0]  id_funct,
  input  logic [1:0]  id_aluop,
  input  logic        id_alusrc,
  input  logic        id_regdst,
  input  logic        id_regwrite,
  input  logic        id_memread,
  input  logic        id_memwrite,
  input  logic        id_memtoreg,
  input  logic        flush,
  input  logic        exmem_regwrite,
  input  logic [4:0]  exmem_rd,
  input  logic [31:0] exmem_result,
  input  logic        memwb_regwrite,
  input  logic [4:0]  memwb_rd,
  input  logic [31:0] memwb_wdata,
  output logic        stall,
  output logic        ex_valid,
  output logic [2:0]  ALUctr,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [31:0] ex_storedata,
  output logic [4:0]  ex_wreg,
  output logic        ex_regwrite,
  output logic        ex_memread,
  output logic        ex_memwrite,
  output logic        ex_memtoreg
);

  localparam logic [2:0] CTR_AND  = 3'b000;
  localparam logic [2:0] CTR_OR   = 3'b001;
  localparam logic [2:0] CTR_ADD  = 3'b010;
  localparam logic [2:0] CTR_ZERO = 3'b011;
  localparam logic [2:0] CTR_SUB  = 3'b110;
  localparam logic [2:0] CTR_SLT  = 3'b111;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  wreg;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [31:0] imm;
    logic [2:0]  aluctr;
    logic        alusrc;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        memtoreg;
  } ex_reg_t;

  ex_reg_t    ex_q;
  ex_reg_t    id_d;
  ex_reg_t    bubble;
  logic [2:0] id_aluctr;
  logic       hazard;

  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    id_aluctr = CTR_ADD;
    unique case (id_aluop)
      2'b00: id_aluctr = CTR_ADD;
      2'b01: id_aluctr = CTR_SUB;
      2'b11: id_aluctr = CTR_OR;
      2'b10: begin
        case (id_funct)
          6'b100000: id_aluctr = CTR_ADD;
          6'b100010: id_aluctr = CTR_SUB;
          6'b100100: id_aluctr = CTR_AND;
          6'b100101: id_aluctr = CTR_OR;
          6'b101010: id_aluctr = CTR_SLT;
          default:   id_aluctr = CTR_ZERO;
        endcase
      end
      default: id_aluctr = CTR_ADD;
    endcase
  end

  always_comb begin
    id_d          = '0;
    id_d.valid    = id_valid;
    id_d.rs       = id_rs;
    id_d.rt       = id_rt;
    id_d.wreg     = id_regdst ? id_rd : id_rt;
    id_d.rdata1   = id_rdata1;
    id_d.rdata2   = id_rdata2;
    id_d.imm      = id_imm;
    id_d.aluctr   = id_aluctr;
    id_d.alusrc   = id_alusrc;
    id_d.regwrite = id_regwrite;
    id_d.memread  = id_memread;
    id_d.memwrite = id_memwrite;
    id_d.memtoreg = id_memtoreg;
  end

  // A bubble is all zero except ALUctr, which idles at add; it doubles as the reset value.
  always_comb begin
    bubble        = '0;
    bubble.aluctr = CTR_ADD;
  end

  // The rt match is deliberately conservative: it stalls even when rt is unused.
  assign hazard = ex_q.valid & ex_q.memread & id_valid & (ex_q.wreg != 5'd0) &
                  ((ex_q.wreg == id_rs) | (ex_q.wreg == id_rt));
  assign stall  = hazard & ~flush;

  // NOTE: sequential state uses non-blocking assignment so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || flush || hazard) ex_q <= bubble;
    else                        ex_q <= id_d;
  end

  function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] regval);
    if (exmem_regwrite && exmem_rd != 5'd0 && exmem_rd == r)      return exmem_result;
    else if (memwb_regwrite && memwb_rd != 5'd0 && memwb_rd == r) return memwb_wdata;
    else                                                          return regval;
  endfunction

  assign ex_valid     = ex_q.valid;
  assign ALUctr       = ex_q.aluctr;
  assign A            = fwd(ex_q.rs, ex_q.rdata1);
  assign ex_storedata = fwd(ex_q.rt, ex_q.rdata2);
  assign B            = ex_q.alusrc ? ex_q.imm : ex_storedata;
  assign ex_wreg      = ex_q.wreg;
  assign ex_regwrite  = ex_q.valid & ex_q.regwrite;
  assign ex_memread   = ex_q.valid & ex_q.memread;
  assign ex_memwrite  = ex_q.valid & ex_q.memwrite;
  assign ex_memtoreg  = ex_q.valid & ex_q.memtoreg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus randomized traffic checked
// against a model that holds the raw captured ID instruction.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rdata1, id_rdata2, id_imm;
  logic [5:0]  id_funct;
  logic [1:0]  id_aluop;
  logic        id_alusrc, id_regdst, id_regwrite, id_memread, id_memwrite, id_memtoreg;
  logic        flush;
  logic        exmem_regwrite;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result;
  logic        memwb_regwrite;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_wdata;
  logic        stall, ex_valid;
  logic [2:0]  ALUctr;
  logic [31:0] A, B, ex_storedata;
  logic [4:0]  ex_wreg;
  logic        ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
    .id_funct(id_funct), .id_aluop(id_aluop),
    .id_alusrc(id_alusrc), .id_regdst(id_regdst), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
    .flush(flush),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_wdata(memwb_wdata),
    .stall(stall), .ex_valid(ex_valid), .ALUctr(ALUctr), .A(A), .B(B),
    .ex_storedata(ex_storedata), .ex_wreg(ex_wreg),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg)
  );

  // Model state: the ID instruction as presented when it was captured.
  typedef struct packed {
    logic        valid;
    logic [4:0]  rs, rt, rd;
    logic [31:0] d1, d2, imm;
    logic [5:0]  funct;
    logic [1:0]  aluop;
    logic        alusrc, regdst, rw, mr, mw, mt;
  } inst_t;

  inst_t m = '0;
  logic  last_stall = 1'b0;

  function automatic logic [2:0] ctr_of(input logic [1:0] aluop, input logic [5:0] funct);
    if (aluop == 2'b00) return 3'b010;
    if (aluop == 2'b01) return 3'b110;
    if (aluop == 2'b11) return 3'b001;
    if (funct == 6'h20) return 3'b010;
    if (funct == 6'h22) return 3'b110;
    if (funct == 6'h24) return 3'b000;
    if (funct == 6'h25) return 3'b001;
    if (funct == 6'h2a) return 3'b111;
    return 3'b011;
  endfunction

  function automatic logic [31:0] mfwd(input logic [4:0] r, input logic [31:0] v);
    if (r == 5'd0) return v;
    if (exmem_regwrite && exmem_rd == r) return exmem_result;
    if (memwb_regwrite && memwb_rd == r) return memwb_wdata;
    return v;
  endfunction

  function automatic logic [4:0] mdest();
    return m.regdst ? m.rd : m.rt;
  endfunction

  function automatic logic mhazard();
    return m.valid && m.mr && id_valid && mdest() != 5'd0 &&
           (mdest() == id_rs || mdest() == id_rt);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_now(input string tag);
    logic [31:0] fb;
    #1;
    fb = mfwd(m.rt, m.d2);
    last_stall = mhazard() && !flush;
    check({tag, ".stall"},     32'(stall),        32'(last_stall));
    check({tag, ".ex_valid"},  32'(ex_valid),     32'(m.valid));
    check({tag, ".ALUctr"},    32'(ALUctr),       32'(ctr_of(m.aluop, m.funct)));
    check({tag, ".A"},         A,                 mfwd(m.rs, m.d1));
    check({tag, ".B"},         B,                 m.alusrc ? m.imm : fb);
    check({tag, ".storedata"}, ex_storedata,      fb);
    check({tag, ".wreg"},      32'(ex_wreg),      32'(mdest()));
    check({tag, ".regwrite"},  32'(ex_regwrite),  32'(m.valid & m.rw));
    check({tag, ".memread"},   32'(ex_memread),   32'(m.valid & m.mr));
    check({tag, ".memwrite"},  32'(ex_memwrite),  32'(m.valid & m.mw));
    check({tag, ".memtoreg"},  32'(ex_memtoreg),  32'(m.valid & m.mt));
  endtask

  task automatic model_update();
    if (rst || flush || mhazard()) m = '0;
    else m = '{valid: id_valid, rs: id_rs, rt: id_rt, rd: id_rd,
               d1: id_rdata1, d2: id_rdata2, imm: id_imm, funct: id_funct,
               aluop: id_aluop, alusrc: id_alusrc, regdst: id_regdst,
               rw: id_regwrite, mr: id_memread, mw: id_memwrite, mt: id_memtoreg};
  endtask

  task automatic cycle(input string tag);
    check_now(tag);
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic set_inst(input logic [4:0] rs, rt, rd, input logic [31:0] d1, d2, imm,
                          input logic [1:0] aluop, input logic [5:0] funct,
                          input logic alusrc, regdst, rw, mr, mw, mt);
    id_valid = 1'b1; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rdata1 = d1; id_rdata2 = d2; id_imm = imm; id_aluop = aluop; id_funct = funct;
    id_alusrc = alusrc; id_regdst = regdst; id_regwrite = rw;
    id_memread = mr; id_memwrite = mw; id_memtoreg = mt;
  endtask

  task automatic fwd_off();
    exmem_regwrite = 1'b0; exmem_rd = 5'd0; exmem_result = '0;
    memwb_regwrite = 1'b0; memwb_rd = 5'd0; memwb_wdata = '0;
  endtask

  task automatic load_lw8();
    set_inst(5'd1, 5'd8, 5'd0, 32'h100, 32'h0, 32'h4, 2'b00, 6'h00, 1, 0, 1, 1, 0, 1);
  endtask

  task automatic add_uses8();
    set_inst(5'd8, 5'd9, 5'd10, 32'h0, 32'h3, 32'h0, 2'b10, 6'h20, 0, 1, 1, 0, 0, 0);
  endtask

  task automatic rand_inputs();
    logic [5:0] functs [6];
    functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00};
    if (!last_stall) begin
      id_valid = ($urandom_range(0, 7) != 0);
      id_rs = 5'($urandom_range(0, 7)); id_rt = 5'($urandom_range(0, 7));
      id_rd = 5'($urandom_range(0, 7));
      id_rdata1 = $urandom; id_rdata2 = $urandom; id_imm = $urandom;
      id_aluop = 2'($urandom);
      id_funct = ($urandom_range(0, 3) == 0) ? 6'($urandom) : functs[$urandom_range(0, 5)];
      id_alusrc = 1'($urandom); id_regdst = 1'($urandom); id_regwrite = 1'($urandom);
      id_memread = ($urandom_range(0, 2) == 0); id_memwrite = 1'($urandom);
      id_memtoreg = 1'($urandom);
    end
    exmem_regwrite = 1'($urandom); exmem_rd = 5'($urandom_range(0, 7)); exmem_result = $urandom;
    memwb_regwrite = 1'($urandom); memwb_rd = 5'($urandom_range(0, 7)); memwb_wdata = $urandom;
    flush = ($urandom_range(0, 9) == 0);
    rst   = ($urandom_range(0, 49) == 0);
  endtask

  initial begin
    // Reset with non-zero ID inputs; the first edge puts the DUT in a known state.
    rst = 1'b1; flush = 1'b0; fwd_off();
    exmem_regwrite = 1'b1; exmem_rd = 5'd3; exmem_result = 32'hDEAD;
    set_inst(5'd3, 5'd4, 5'd5, 32'h11, 32'h22, 32'h33, 2'b10, 6'h2a, 1, 1, 1, 1, 1, 1);
    @(posedge clk); model_update(); @(negedge clk);
    check_now("reset");
    check("reset.ALUctr_lit", 32'(ALUctr), 32'd2);
    check("reset.A_lit", A, 32'd0);
    check("reset.stall_lit", 32'(stall), 32'd0);
    cycle("reset_hold");
    rst = 1'b0; fwd_off();

    // R-type decode
    set_inst(5'd1, 5'd2, 5'd3, 32'd5, 32'd9, 32'h0, 2'b10, 6'b101010, 0, 1, 1, 0, 0, 0);
    cycle("rtype_load");
    id_funct = 6'b000000;
    check_now("rtype_slt");
    check("rtype.ALUctr_lit", 32'(ALUctr), 32'b111);
    check("rtype.A_lit", A, 32'd5);
    check("rtype.B_lit", B, 32'd9);
    check("rtype.wreg_lit", 32'(ex_wreg), 32'd3);
    check("rtype.regwrite_lit", 32'(ex_regwrite), 32'd1);
    cycle("rtype_funct0_load");
    check_now("rtype_funct0");
    check("rtype0.ALUctr_lit", 32'(ALUctr), 32'b011);

    // Forwarding priority
    set_inst(5'd4, 5'd6, 5'd7, 32'd1, 32'd2, 32'h0, 2'b00, 6'h00, 0, 1, 1, 0, 0, 0);
    cycle("fwd_load");
    exmem_regwrite = 1'b1; exmem_rd = 5'd4; exmem_result = 32'hAAAA;
    memwb_regwrite = 1'b1; memwb_rd = 5'd4; memwb_wdata  = 32'hBBBB;
    check_now("fwd_both");
    check("fwd_both.A_lit", A, 32'hAAAA);
    exmem_regwrite = 1'b0;
    check_now("fwd_memwb");
    check("fwd_memwb.A_lit", A, 32'hBBBB);
    set_inst(5'd0, 5'd6, 5'd7, 32'h55, 32'h2, 32'h0, 2'b00, 6'h00, 0, 1, 1, 0, 0, 0);
    cycle("fwd_r0_load");
    exmem_regwrite = 1'b1; exmem_rd = 5'd0; memwb_rd = 5'd0;
    check_now("fwd_r0");
    check("fwd_r0.A_lit", A, 32'h55);

    // Immediate select with forwarded store data
    fwd_off();
    set_inst(5'd0, 5'd5, 5'd0, 32'h0, 32'h9999, 32'hFFFF_FFFC, 2'b00, 6'h00, 1, 0, 0, 0, 1, 0);
    cycle("imm_load");
    memwb_regwrite = 1'b1; memwb_rd = 5'd5; memwb_wdata = 32'h1234;
    check_now("imm");
    check("imm.B_lit", B, 32'hFFFF_FFFC);
    check("imm.storedata_lit", ex_storedata, 32'h1234);

    // Load-use: one stall cycle, one bubble, then MEM/WB forwarding
    fwd_off();
    load_lw8();
    cycle("lu_lw");
    add_uses8();
    check_now("lu_stall");
    check("lu.stall_lit", 32'(stall), 32'd1);
    cycle("lu_stall_edge");
    check_now("lu_bubble");
    check("lu.bubble_stall_lit", 32'(stall), 32'd0);
    check("lu.bubble_regwrite_lit", 32'(ex_regwrite), 32'd0);
    cycle("lu_add_load");
    memwb_regwrite = 1'b1; memwb_rd = 5'd8; memwb_wdata = 32'h77;
    check_now("lu_add");
    check("lu.add_A_lit", A, 32'h77);
    check("lu.add_regwrite_lit", 32'(ex_regwrite), 32'd1);

    // Flush without and with a concurrent hazard
    fwd_off();
    set_inst(5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3, 2'b10, 6'h20, 0, 1, 1, 0, 1, 0);
    flush = 1'b1;
    cycle("flush_plain");
    flush = 1'b0;
    check_now("flush_plain_after");
    check("flush.valid_lit", 32'(ex_valid), 32'd0);
    check("flush.memwrite_lit", 32'(ex_memwrite), 32'd0);
    load_lw8();
    cycle("flush_hz_lw");
    add_uses8();
    flush = 1'b1;
    check_now("flush_hz");
    check("flush_hz.stall_lit", 32'(stall), 32'd0);
    cycle("flush_hz_edge");
    flush = 1'b0;
    check_now("flush_hz_after");
    check("flush_hz.valid_lit", 32'(ex_valid), 32'd0);

    // Reset during a stall
    load_lw8();
    cycle("rst_stall_lw");
    add_uses8();
    rst = 1'b1;
    cycle("rst_stall");
    rst = 1'b0;
    check_now("rst_stall_after");
    check("rst_stall.stall_lit", 32'(stall), 32'd0);

    // Invalid ID instruction never stalls
    load_lw8();
    cycle("inv_lw");
    add_uses8();
    id_valid = 1'b0;
    check_now("inv_id");
    check("inv_id.stall_lit", 32'(stall), 32'd0);
    cycle("inv_id_edge");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
